// File: rtl/seq_pkg.sv
// Shared definitions for the sequencer: opcode constants, FSM state
// encoding, ALU operation encodings and the decoded-control bundle that
// the combinational decoder hands to the FSM.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0101;
    localparam logic [3:0] OP_NOP  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b0111;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e alu_ctrl;
        logic      alu_src;
        logic      is_branch;
        logic      is_nop;
        logic      is_halt;
        logic      is_illegal;
    } dec_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational control unit: latched opcode -> ALU select, operand
// source and instruction-class flags.
// Ports:
//   opcode_i  latched 4-bit opcode
//   dec_o     decoded control bundle (seq_pkg::dec_t)
module seq_decode
    import seq_pkg::*;
(
    input  logic [3:0] opcode_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o          = '0;
        dec_o.alu_ctrl = ALU_ADD;
        case (opcode_i)
            OP_ADD:  dec_o.alu_ctrl = ALU_ADD;
            OP_SUB:  dec_o.alu_ctrl = ALU_SUB;
            OP_AND:  dec_o.alu_ctrl = ALU_AND;
            OP_OR:   dec_o.alu_ctrl = ALU_OR;
            OP_ADDI: begin
                dec_o.alu_ctrl = ALU_ADD;
                dec_o.alu_src  = 1'b1;
            end
            OP_BEQ: begin
                dec_o.alu_ctrl  = ALU_SUB;
                dec_o.is_branch = 1'b1;
            end
            OP_NOP:  dec_o.is_nop  = 1'b1;
            OP_HALT: dec_o.is_halt = 1'b1;
            // 1000-1111 are unassigned
            default: dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXECUTE ->
// WRITEBACK, with NOP/BEQ shortcuts and a terminal HALT state.
// Ports:
//   clk, reset            clock, async active-high reset
//   start                 leave IDLE
//   imem_req/imem_ready   fetch handshake; opcode valid with imem_ready
//   zero                  ALU zero flag sampled in EXECUTE (BEQ)
//   ir_load, pc_inc,
//   pc_branch, reg_write  one-cycle datapath strobes
//   alu_en, ALUControl,
//   ALUSrc                ALU control during EXECUTE/WRITEBACK
//   busy, halted, illegal status
//   retired               completed-instruction count (wraps)
module seq_controller
    import seq_pkg::*;
#(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                imem_req,
    input  logic                imem_ready,
    input  logic [3:0]          opcode,
    input  logic                zero,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_branch,
    output logic                alu_en,
    output logic [1:0]          ALUControl,
    output logic                ALUSrc,
    output logic                reg_write,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    state_e                state_q, state_d;
    logic [3:0]            opcode_q, opcode_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    logic                  retire;
    dec_t                  dec;

    seq_decode u_decode (
        .opcode_i (opcode_q),
        .dec_o    (dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            opcode_q  <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        retire     = 1'b0;
        imem_req   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_branch  = 1'b0;
        alu_en     = 1'b0;
        ALUControl = 2'b00;
        ALUSrc     = 1'b0;
        reg_write  = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                busy     = 1'b1;
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load  = 1'b1;
                    pc_inc   = 1'b1;
                    opcode_d = opcode;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                busy = 1'b1;
                if (dec.is_halt || dec.is_illegal) begin
                    state_d = ST_HALT;
                end else if (dec.is_nop) begin
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                busy       = 1'b1;
                alu_en     = 1'b1;
                ALUControl = dec.alu_ctrl;
                ALUSrc     = dec.alu_src;
                if (dec.is_branch) begin
                    pc_branch = zero;
                    retire    = 1'b1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                busy       = 1'b1;
                reg_write  = 1'b1;
                ALUControl = dec.alu_ctrl;
                ALUSrc     = dec.alu_src;
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        retired_d = retired_q + {{(RETIRE_W-1){1'b0}}, retire};
    end

    // HALT is only left by reset and nothing is fetched there, so the latched
    // opcode still identifies why we halted; that makes illegal sticky without
    // a dedicated flop.
    assign illegal = (state_q == ST_HALT) && dec.is_illegal;
    assign retired = retired_q;

endmodule

// File: tb/tb_seq_controller.sv
module tb_seq_controller;

    logic        clk = 1'b0;
    logic        reset, start, imem_ready, zero;
    logic [3:0]  opcode;
    logic        imem_req, ir_load, pc_inc, pc_branch, alu_en, ALUSrc, reg_write;
    logic        busy, halted, illegal;
    logic [1:0]  ALUControl;
    logic [15:0] retired;

    // narrow-counter instance fed a stream of NOPs
    logic        start4, ready4, zero4;
    logic [3:0]  opcode4;
    logic        req4, irl4, pinc4, pbr4, alu4, src4, rw4, busy4, halt4, ill4;
    logic [1:0]  ctl4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    seq_controller dut (
        .clk(clk), .reset(reset), .start(start), .imem_req(imem_req),
        .imem_ready(imem_ready), .opcode(opcode), .zero(zero),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch),
        .alu_en(alu_en), .ALUControl(ALUControl), .ALUSrc(ALUSrc),
        .reg_write(reg_write), .busy(busy), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    seq_controller #(.RETIRE_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .imem_req(req4),
        .imem_ready(ready4), .opcode(opcode4), .zero(zero4),
        .ir_load(irl4), .pc_inc(pinc4), .pc_branch(pbr4),
        .alu_en(alu4), .ALUControl(ctl4), .ALUSrc(src4),
        .reg_write(rw4), .busy(busy4), .halted(halt4),
        .illegal(ill4), .retired(retired4)
    );

    wire [27:0] all_out = {imem_req, ir_load, pc_inc, pc_branch, alu_en, ALUControl,
                           ALUSrc, reg_write, busy, halted, illegal, retired};

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {EV_FETCH, EV_EXEC, EV_WB} kind_e;
    typedef struct {
        kind_e      kind;
        logic [1:0] ctrl;
        logic       src;
        logic       br;
        int         ret;
        int         gap;
    } ev_t;

    ev_t q[$];
    int  r_model   = 0;
    int  prev_base = 0;
    bit  first     = 1'b1;

    // opcode -> (ALUControl, ALUSrc) as listed in the opcode map
    function automatic void op_map(input logic [3:0] op, output logic [1:0] c, output logic s);
        case (op)
            4'd0: begin c = 2'b00; s = 1'b0; end
            4'd1: begin c = 2'b01; s = 1'b0; end
            4'd2: begin c = 2'b10; s = 1'b0; end
            4'd3: begin c = 2'b11; s = 1'b0; end
            4'd4: begin c = 2'b00; s = 1'b1; end
            4'd5: begin c = 2'b01; s = 1'b0; end
            default: begin c = 2'b00; s = 1'b0; end
        endcase
    endfunction

    // issue one instruction: wait for the fetch request, stall w cycles,
    // then present the opcode; expected observable events are queued.
    task automatic do_instr(input logic [3:0] op, input int w, input bit z, input bit abort);
        int   n;
        ev_t  e;
        logic [1:0] c;
        logic s;
        n = 0;
        while (!imem_req && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("fetch_req_seen", imem_req, 1);
        zero = z;
        for (int i = 0; i < w; i++) begin
            chk("imem_req_held", imem_req, 1);
            @(posedge clk); #1;
        end
        op_map(op, c, s);
        e = '{kind: EV_FETCH, ctrl: 2'b00, src: 1'b0, br: 1'b0, ret: r_model,
              gap: first ? -1 : prev_base + w};
        q.push_back(e);
        if (op <= 4'd4) begin
            q.push_back('{kind: EV_EXEC, ctrl: c, src: s, br: 1'b0, ret: 0, gap: 0});
            if (!abort) begin
                q.push_back('{kind: EV_WB, ctrl: c, src: s, br: 1'b0, ret: 0, gap: 0});
                r_model++;
            end
            prev_base = 4;
        end else if (op == 4'd5) begin
            q.push_back('{kind: EV_EXEC, ctrl: c, src: s, br: z, ret: 0, gap: 0});
            r_model++;
            prev_base = 3;
        end else if (op == 4'd6) begin
            r_model++;
            prev_base = 2;
        end
        first      = 1'b0;
        imem_ready = 1'b1;
        opcode     = op;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        opcode     = 4'($urandom);
    endtask

    // ---------------- monitor ----------------
    int cyc = 0;
    int last_fetch = 0;

    always @(negedge clk) begin
        ev_t e;
        cyc++;
        if (!reset) begin
            chk("strobe_exclusive", {pc_inc & pc_branch, ir_load & reg_write}, 0);
            if (ir_load) begin
                chk("sb_fetch_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("fetch_kind", e.kind, EV_FETCH);
                    chk("fetch_pc_inc", pc_inc, 1);
                    chk("fetch_busy", busy, 1);
                    chk("fetch_retired", retired, e.ret);
                    if (e.gap >= 0) chk("fetch_latency", cyc - last_fetch, e.gap);
                end
                last_fetch = cyc;
            end
            if (alu_en) begin
                chk("sb_exec_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("exec_kind", e.kind, EV_EXEC);
                    chk("exec_aluctrl", ALUControl, e.ctrl);
                    chk("exec_alusrc", ALUSrc, e.src);
                    chk("exec_pc_branch", pc_branch, e.br);
                    chk("exec_no_regwrite", reg_write, 0);
                end
            end else begin
                chk("branch_outside_exec", pc_branch, 0);
            end
            if (reg_write) begin
                chk("sb_wb_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("wb_kind", e.kind, EV_WB);
                    chk("wb_aluctrl", ALUControl, e.ctrl);
                    chk("wb_alusrc", ALUSrc, e.src);
                end
            end
        end
    end

    // narrow counter wraps from 1111 to 0000 on the 16th retirement
    int k4 = 0;
    always @(negedge clk) begin
        if (!reset && irl4 && k4 < 20) begin
            chk("wrap_retired4", retired4, k4 % 16);
            k4++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; start = 1'b0; imem_ready = 1'b0; opcode = 4'd0; zero = 1'b0;
        start4 = 1'b1; ready4 = 1'b1; opcode4 = 4'b0110; zero4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", all_out, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_outputs_zero", all_out, 0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        do_instr(4'b0000, 0, 1'b0, 1'b0);   // ADD, zero-wait
        do_instr(4'b0100, 3, 1'b0, 1'b0);   // ADDI, 3 stall cycles
        do_instr(4'b0101, 0, 1'b1, 1'b0);   // BEQ taken
        do_instr(4'b0101, 1, 1'b0, 1'b0);   // BEQ not taken
        do_instr(4'b0110, 0, 1'b0, 1'b0);   // NOP
        for (int i = 0; i < 40; i++)
            do_instr(4'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'b0);
        do_instr(4'b0111, 0, 1'b0, 1'b0);   // HALT
        repeat (2) @(posedge clk);
        #1;
        chk("halt_halted", halted, 1);
        chk("halt_not_illegal", illegal, 0);
        chk("halt_not_busy", busy, 0);
        chk("halt_retired", retired, r_model);

        // illegal opcode path
        reset = 1'b1; #3; reset = 1'b0;
        r_model = 0; first = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        do_instr(4'b0000, 0, 1'b0, 1'b0);
        do_instr(4'b1010, 1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("illegal_set", illegal, 1);
        chk("illegal_halted", halted, 1);
        chk("illegal_retired", retired, r_model);
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        chk("halt_ignores_start_req", imem_req, 0);
        chk("halt_ignores_start", halted, 1);
        chk("illegal_sticky", illegal, 1);

        // reset while heading into WRITEBACK
        reset = 1'b1; #3; reset = 1'b0;
        r_model = 0; first = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        do_instr(4'b0001, 0, 1'b0, 1'b1);   // SUB, to be aborted
        @(posedge clk); #1;
        chk("abort_in_execute", alu_en, 1);
        #5;
        reset = 1'b1;
        #1;
        chk("abort_async_zero", all_out, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_regwrite", reg_write, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_idle_zero", all_out, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        chk("wrap_checks_done", k4, 20);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 Parameter: RETIRE_W, default 16, width of the retired-instruction counter.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  level; begins execution when sampled high in IDLE.
REQ-005 Port: imem_req  output  1  instruction-fetch request to instruction memory.
REQ-006 Port: imem_ready  input  1  fetch completes in any cycle where imem_req && imem_ready.
REQ-007 Port: opcode  input  4  instruction opcode from the instruction word, valid while imem_ready is high.
REQ-008 Port: zero  input  1  ALU zero flag, valid in EXECUTE.
REQ-009 Port: ir_load  output  1  one-cycle strobe: load instruction register.
REQ-010 Port: pc_inc  output  1  one-cycle strobe: PC += 1.
REQ-011 Port: pc_branch  output  1  one-cycle strobe: PC <= branch target.
REQ-012 Port: alu_en  output  1  ALU operation active.
REQ-013 Port: ALUControl  output  2  ALU operation select.
REQ-014 Port: ALUSrc  output  1  0 = register operand, 1 = immediate operand.
REQ-015 Port: reg_write  output  1  one-cycle register-file write strobe.
REQ-016 Port: busy  output  1  high in every state except IDLE and HALT.
REQ-017 Port: halted  output  1  high in HALT.
REQ-018 Port: illegal  output  1  sticky; set when an illegal opcode is decoded.
REQ-019 Port: retired  output  RETIRE_W  count of completed instructions.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT; encoding lives in the package.
REQ-021 IDLE: start=1 moves to FETCH; start has no effect in any other state.
REQ-022 FETCH: imem_req=1 and held until imem_ready=1; imem_req shall not drop earlier.
REQ-023 FETCH with imem_ready=1: in the same cycle ir_load=1, pc_inc=1 and opcode is latched internally; the next state is DECODE.
REQ-024 DECODE, one cycle:
- HALT (0111) goes to HALT.
- NOP (0110) retires and goes to FETCH.
- Illegal opcodes (1000-1111) set illegal and go to HALT without retiring.
- All other opcodes go to EXECUTE.
REQ-025 Opcode map (ALUControl, ALUSrc):
- ADD 0000 = (00, 0)
- SUB 0001 = (01, 0)
- AND 0010 = (10, 0)
- OR 0011 = (11, 0)
- ADDI 0100 = (00, 1)
- BEQ 0101 = (01, 0)
REQ-026 EXECUTE: alu_en=1, and ALUControl/ALUSrc are driven from the latched opcode; outside EXECUTE and WRITEBACK they are 00 and 0.
REQ-027 EXECUTE with BEQ: pc_branch=zero in that cycle, the instruction retires, and the next state is FETCH; any other opcode goes to WRITEBACK.
REQ-028 WRITEBACK: reg_write=1 for exactly one cycle, ALUControl/ALUSrc are held, the instruction retires, and the next state is FETCH.
REQ-029 HALT: halted=1; the block stays in HALT until reset.
REQ-030 Latency with zero-wait fetch (FETCH to next FETCH):
- ALU op: 4 cycles.
- BEQ: 3 cycles.
- NOP: 2 cycles.
- Each imem_ready wait cycle adds 1.
REQ-031 retired increments by exactly 1 per retirement and wraps from all-ones to 0.
REQ-032 pc_inc and pc_branch shall never be high in the same cycle; ir_load and reg_write shall never be high in the same cycle.

Reset
REQ-033 While reset=1: state=IDLE, retired=0, illegal=0, and every output is 0, regardless of clk.
REQ-034 Reset asserted mid-instruction abandons that instruction: no reg_write and no pc strobe occur after reset asserts.
REQ-035 After reset deasserts, the block waits in IDLE for start.

Structure
REQ-036 Package seq_pkg holds the opcode constants, the state enum and the ALUControl encodings; it is shared with the combinational control unit.
REQ-037 One sub-module, seq_decode, is purely combinational: latched opcode -> {ALUControl, ALUSrc, is_branch, is_nop, is_halt, is_illegal}.
REQ-038 The FSM state register and the retired counter are the only sequential elements besides the latched opcode.

Verification
REQ-039 Reset, start, ADD with imem_ready=1 -> ir_load/pc_inc at cycle 1, alu_en at cycle 3 with ALUControl=00, reg_write at cycle 4, retired=1.
REQ-040 ADDI with imem_ready low for 3 cycles -> imem_req held 4 cycles, ALUSrc=1 in EXECUTE, retired=1.
REQ-041 BEQ with zero=1, then BEQ with zero=0 -> pc_branch pulses only on the first, no reg_write, retired=2.
REQ-042 Opcode 1010 -> illegal=1, halted=1, retired unchanged; a later start is ignored.
REQ-043 Preload retired=all-ones via a RETIRE_W=4 instance, then execute one NOP -> retired=0.
REQ-044 Assert reset during WRITEBACK entry -> reg_write never pulses, and all outputs are 0 immediately (asynchronously).
